calc_seq: RTL

CALC_SEQ -- requirements
Module: calc_seq

---
 rtl/calc_seq.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/calc_seq.sv
// calc_seq: sequential decimal calculator with BCD digit output.
// Shift-add multiply and double-dabble conversion, one bit per cycle.
module calc_seq #(
  parameter  int MAX_DIGITS = 8,
  parameter  int WIDTH      = 32,
  localparam int PW = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_valid,
  input  logic [3:0]    cmd,
  output logic          cmd_ready,
  output logic [1:0]    status,
  output logic [3:0]    data,
  output logic [PW-1:0] position,
  output logic          data_valid
);

  localparam int CW  = $clog2(MAX_DIGITS + 1);
  localparam int BW  = $clog2(WIDTH + 1);
  localparam int DW  = 4 * MAX_DIGITS;
  localparam int PWD = 2 * WIDTH;

  localparam logic [3:0] C_ADD = 4'hA;
  localparam logic [3:0] C_MUL = 4'hC;
  localparam logic [3:0] C_RES = 4'hE;
  localparam logic [3:0] C_CLR = 4'hF;

  function automatic logic [PWD-1:0] f_limit();
    logic [PWD-1:0] v;
    v = PWD'(1);
    for (int i = 0; i < MAX_DIGITS; i++)
      v = v * PWD'(10);
    return v - PWD'(1);
  endfunction

  localparam logic [PWD-1:0] LIMIT = f_limit();

  typedef enum logic [2:0] {
    S_IDLE, S_IN_A, S_IN_B, S_MUL,
    S_CONV, S_OUT, S_DONE, S_ERR
  } state_t;

  state_t r_state, w_nx;

  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_op;
  logic [PWD-1:0]   r_prod, r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [BW-1:0]    r_bit;
  logic [DW-1:0]    r_bcd;
  logic [WIDTH-1:0] r_shift;
  logic [PW-1:0]    r_oidx;

  logic             w_acc, w_dig, w_op, w_clr, w_room, w_last;
  logic             w_exe, w_add_ovf, w_sub_ok, w_mul_ovf;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_arith, w_a_nx, w_b_nx, w_d;
  logic [PWD-1:0]   w_mul_nx;
  logic [DW-1:0]    w_dd;
  state_t           w_exec_st;

  assign w_acc  = cmd_valid && cmd_ready;
  assign w_dig  = cmd <= 4'd9;
  assign w_op   = cmd >= 4'hA && cmd <= 4'hC;
  assign w_clr  = cmd == C_CLR;
  assign w_room = r_cnt < CW'(MAX_DIGITS);
  assign w_last = r_bit == BW'(WIDTH - 1);
  assign w_exe  = cmd == C_RES && r_cnt != '0;
  assign w_d    = WIDTH'(cmd);

  // count limit guarantees the *10 never wraps
  assign w_a_nx = r_a * WIDTH'(10) + w_d;
  assign w_b_nx = r_b * WIDTH'(10) + w_d;

  assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
  assign w_add_ovf = PWD'(w_sum) > LIMIT;
  assign w_sub_ok  = r_a >= r_b;
  assign w_arith   = (r_op == C_ADD) ? w_sum[WIDTH-1:0]
                                     : r_a - r_b;
  assign w_mul_nx  = r_mplier[0] ? r_prod + r_mcand : r_prod;
  assign w_mul_ovf = w_mul_nx > LIMIT;

  always_comb begin
    unique case (1'b1)
      r_op == C_MUL: w_exec_st = S_MUL;
      r_op == C_ADD: w_exec_st = w_add_ovf ? S_ERR : S_CONV;
      default:       w_exec_st = w_sub_ok ? S_CONV : S_ERR;
    endcase
  end

  always_comb begin
    w_dd = r_bcd;
    for (int i = 0; i < MAX_DIGITS; i++)
      if (r_bcd[4*i +: 4] >= 4'd5)
        w_dd[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
  end

  always_comb begin
    w_nx = r_state;
    case (r_state)
      S_IDLE:
        if (w_acc && w_dig) w_nx = S_IN_A;
      S_IN_A:
        if (w_acc) begin
          if (w_dig)     w_nx = w_room ? S_IN_A : S_ERR;
          else if (w_op) w_nx = S_IN_B;
        end
      S_IN_B:
        if (w_acc) begin
          if (w_dig)      w_nx = w_room ? S_IN_B : S_ERR;
          else if (w_exe) w_nx = w_exec_st;
        end
      S_MUL:
        if (w_last) w_nx = w_mul_ovf ? S_ERR : S_CONV;
      S_CONV:
        if (w_last) w_nx = S_OUT;
      S_OUT:
        if (r_oidx == PW'(MAX_DIGITS - 1)) w_nx = S_DONE;
      S_DONE:
        if (w_acc) begin
          if (w_dig)     w_nx = S_IN_A;
          else if (w_op) w_nx = S_IN_B;
        end
      default: ;
    endcase
    if (w_acc && w_clr) w_nx = S_IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nx;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset || (w_acc && w_clr)) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_bit    <= '0;
      r_bcd    <= '0;
      r_shift  <= '0;
      r_oidx   <= '0;
    end else begin
      case (r_state)
        S_IDLE:
          if (w_acc && w_dig) begin
            r_a   <= w_d;
            r_cnt <= CW'(1);
          end
        S_IN_A:
          if (w_acc) begin
            if (w_dig && w_room) begin
              r_a   <= w_a_nx;
              r_cnt <= r_cnt + CW'(1);
            end else if (w_op) begin
              r_op  <= cmd;
              r_b   <= '0;
              r_cnt <= '0;
            end
          end
        S_IN_B:
          if (w_acc) begin
            if (w_dig && w_room) begin
              r_b   <= w_b_nx;
              r_cnt <= r_cnt + CW'(1);
            end else if (w_exe) begin
              r_bit    <= '0;
              r_prod   <= '0;
              r_mcand  <= PWD'(r_a);
              r_mplier <= r_b;
              r_res    <= w_arith;
              r_shift  <= w_arith;
              r_bcd    <= '0;
            end
          end
        S_MUL: begin
          r_prod   <= w_mul_nx;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_bit    <= r_bit + BW'(1);
          if (w_last) begin
            r_res   <= w_mul_nx[WIDTH-1:0];
            r_shift <= w_mul_nx[WIDTH-1:0];
            r_bcd   <= '0;
            r_bit   <= '0;
          end
        end
        S_CONV: begin
          r_bcd   <= {w_dd[DW-2:0], r_shift[WIDTH-1]};
          r_shift <= r_shift << 1;
          r_bit   <= r_bit + BW'(1);
          if (w_last) r_oidx <= '0;
        end
        S_OUT:
          r_oidx <= r_oidx + PW'(1);
        S_DONE:
          if (w_acc) begin
            if (w_dig) begin
              r_a   <= w_d;
              r_cnt <= CW'(1);
            end else if (w_op) begin
              r_a   <= r_res;
              r_op  <= cmd;
              r_b   <= '0;
              r_cnt <= '0;
            end
          end
        default: ;
      endcase
    end
  end

  always_comb begin
    cmd_ready  = 1'b1;
    status     = 2'b00;
    data_valid = 1'b0;
    data       = 4'd0;
    position   = '0;
    unique case (r_state)
      S_MUL, S_CONV: begin
        cmd_ready = 1'b0;
        status    = 2'b01;
      end
      S_OUT: begin
        cmd_ready  = 1'b0;
        status     = 2'b01;
        data_valid = 1'b1;
        data       = r_bcd[{r_oidx, 2'b00} +: 4];
        position   = r_oidx;
      end
      S_DONE: status = 2'b10;
      S_ERR:  status = 2'b11;
      default: ;
    endcase
  end

endmodule
